// File: rtl/kanagawa_weighted_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kanagawa_weighted_rr_arbiter: weighted round-robin merge of N show-ahead   |
// | FIFO sources onto one sink write port. Optional: KANAGAWA_WRR_GRANT_COUNT_EN|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module kanagawa_weighted_rr_arbiter #(
  parameter int NUM_PORTS              = 4,
  parameter int WIDTH                  = 8,
  parameter int IS_TRANSACTIONAL       = 0,
  parameter int END_TRANSACTION_OFFSET = 0,
  parameter int WEIGHT_WIDTH           = 4,
  localparam int PW                    = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0][WIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]            empty_in,
  output logic [NUM_PORTS-1:0]            rden_out,
  output logic [WIDTH-1:0]                data_out,
  output logic                            wren_out,
  input  logic                            full_in,
  input  logic                            cfg_valid,
  input  logic [PW-1:0]                   cfg_port,
  input  logic [WEIGHT_WIDTH-1:0]         cfg_weight,
  output logic [PW-1:0]                   grant_port_out,
  output logic                            locked_out
`ifdef KANAGAWA_WRR_GRANT_COUNT_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]      grant_count_out
`endif
);

  logic [WEIGHT_WIDTH-1:0] weight [NUM_PORTS];
  logic [WEIGHT_WIDTH-1:0] credit;
  logic [PW-1:0]           owner;
  logic                    locked;

  logic [NUM_PORTS-1:0]    elig;
  logic [PW-1:0]           sel;
  logic [WEIGHT_WIDTH-1:0] cur;
  logic                    grant;
  logic                    found;
  logic [PW:0]             scan_idx;
  logic                    wren;
  logic                    end_tx;
  logic                    cfg_hit;

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_elig
      assign elig[i] = !empty_in[i] && (weight[i] != '0);
    end
  endgenerate

  // Lock beats continuation beats rotation; the rotation scan visits the owner last.
  always_comb begin
    sel      = owner;
    cur      = credit;
    grant    = 1'b0;
    found    = 1'b0;
    scan_idx = '0;
    if (locked) begin
      grant = !empty_in[owner];
    end else if (elig[owner] && (credit != '0)) begin
      grant = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        scan_idx = {1'b0, owner} + (PW+1)'(k);
        if (scan_idx >= (PW+1)'(NUM_PORTS)) begin
          scan_idx = scan_idx - (PW+1)'(NUM_PORTS);
        end
        if (!found && elig[scan_idx[PW-1:0]]) begin
          found = 1'b1;
          sel   = scan_idx[PW-1:0];
        end
      end
      grant = found;
      cur   = weight[sel];
    end
  end

  generate
    if (IS_TRANSACTIONAL != 0) begin : g_tx
      assign end_tx = data_in[sel][END_TRANSACTION_OFFSET];
    end else begin : g_no_tx
      assign end_tx = 1'b1;
    end
  endgenerate

  assign wren    = grant && !full_in && rst_n;
  assign cfg_hit = cfg_valid && ({1'b0, cfg_port} < (PW+1)'(NUM_PORTS));

  always_comb begin
    rden_out = '0;
    if (wren) begin
      rden_out[sel] = 1'b1;
    end
  end

  assign wren_out       = wren;
  assign data_out       = data_in[sel];
  assign grant_port_out = rst_n ? sel : '0;
  assign locked_out     = locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  <= PW'(NUM_PORTS - 1);
      credit <= '0;
      locked <= 1'b0;
    end else if (wren) begin
      owner <= sel;
      if (end_tx) begin
        locked <= 1'b0;
        credit <= (cur == '0) ? '0 : cur - WEIGHT_WIDTH'(1);
      end else begin
        // Inside a transaction the budget is frozen until the end word pops.
        locked <= 1'b1;
        credit <= cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        weight[i] <= WEIGHT_WIDTH'(1);
      end
    end else if (cfg_hit) begin
      weight[cfg_port] <= cfg_weight;
    end
  end

`ifdef KANAGAWA_WRR_GRANT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count_out <= '0;
    end else if (wren && (grant_count_out[sel] != 16'hFFFF)) begin
      grant_count_out[sel] <= grant_count_out[sel] + 16'd1;
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_kanagawa_weighted_rr_arbiter.sv
`default_nettype none
// Bench for kanagawa_weighted_rr_arbiter: directed scenarios plus random traffic
// against a spec-level reference model (5 ports, transactional, end bit 7).
module tb_kanagawa_weighted_rr_arbiter;
  localparam int NP   = 5;
  localparam int W    = 8;
  localparam int WW   = 4;
  localparam int PWB  = 3;
  localparam int EOFF = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n = 1'b1;
  logic [NP-1:0][W-1:0]    data_in;
  logic [NP-1:0]           empty_in;
  logic [NP-1:0]           rden_out;
  logic [W-1:0]            data_out;
  logic                    wren_out;
  logic                    full_in;
  logic                    cfg_valid;
  logic [PWB-1:0]          cfg_port;
  logic [WW-1:0]           cfg_weight;
  logic [PWB-1:0]          grant_port_out;
  logic                    locked_out;
`ifdef KANAGAWA_WRR_GRANT_COUNT_EN
  logic [NP-1:0][15:0]     grant_count_out;
`endif

  kanagawa_weighted_rr_arbiter #(
    .NUM_PORTS(NP), .WIDTH(W), .IS_TRANSACTIONAL(1),
    .END_TRANSACTION_OFFSET(EOFF), .WEIGHT_WIDTH(WW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .empty_in(empty_in),
    .rden_out(rden_out), .data_out(data_out), .wren_out(wren_out),
    .full_in(full_in), .cfg_valid(cfg_valid), .cfg_port(cfg_port),
    .cfg_weight(cfg_weight), .grant_port_out(grant_port_out),
    .locked_out(locked_out)
`ifdef KANAGAWA_WRR_GRANT_COUNT_EN
    , .grant_count_out(grant_count_out)
`endif
  );

  // Reference model: per-port budget, current owner, remaining budget, lock flag.
  int m_weight[NP];
  int m_cnt[NP];
  int m_owner, m_credit;
  bit m_locked;
  bit e_wren, e_end;
  int e_sel, e_cur;
  int checks = 0;
  int errors = 0;

  function automatic void m_reset();
    for (int i = 0; i < NP; i++) begin
      m_weight[i] = 1;
      m_cnt[i]    = 0;
    end
    m_owner  = NP - 1;
    m_credit = 0;
    m_locked = 0;
  endfunction

  function automatic void fill(input bit endbit);
    for (int i = 0; i < NP; i++) data_in[i] = {endbit, 3'b000, 4'(i)};
  endfunction

  task automatic predict();
    bit g;
    int s;
    #1;
    g = 0;
    s = m_owner;
    e_cur = m_credit;
    if (m_locked) begin
      g = !empty_in[m_owner];
    end else if (!empty_in[m_owner] && m_weight[m_owner] != 0 && m_credit > 0) begin
      g = 1;
    end else begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_owner + k) % NP;
        if (!g && !empty_in[p] && m_weight[p] != 0) begin
          g = 1;
          s = p;
        end
      end
      if (g) e_cur = m_weight[s];
    end
    e_sel  = s;
    e_wren = g && !full_in;
    e_end  = data_in[s][EOFF];
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_wren) begin
      m_owner = e_sel;
      if (m_cnt[e_sel] < 65535) m_cnt[e_sel]++;
      if (e_end) begin
        m_locked = 0;
        m_credit = (e_cur > 0) ? e_cur - 1 : 0;
      end else begin
        m_locked = 1;
        m_credit = e_cur;
      end
    end
    if (cfg_valid && cfg_port < NP) m_weight[cfg_port] = int'(cfg_weight);
    @(negedge clk);
  endtask

  function automatic logic [17:0] obs_vec();
    return {wren_out, rden_out, e_wren ? grant_port_out : 3'd0,
            e_wren ? data_out : 8'd0, locked_out};
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [NP-1:0] r;
    r = '0;
    if (e_wren) r[e_sel] = 1'b1;
    return {e_wren, r, e_wren ? 3'(e_sel) : 3'd0,
            e_wren ? data_in[e_sel] : 8'd0, m_locked};
  endfunction

  task automatic cfg_write(input int port, input int wt);
    cfg_valid  = 1'b1;
    cfg_port   = 3'(port);
    cfg_weight = 4'(wt);
    predict();
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    empty_in = '1; full_in = 1'b0; cfg_valid = 1'b0; cfg_port = '0; cfg_weight = '0;
    fill(1);
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    empty_in = '0; full_in = 1'b0; cfg_valid = 1'b0; cfg_port = '0; cfg_weight = '0;
    fill(0);
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({wren_out, rden_out, locked_out, grant_port_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0", {wren_out, rden_out, locked_out, grant_port_out});
    end
    empty_in = '1;
    rst_n = 1'b1;
    @(negedge clk);
    predict();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle got %h required %h", obs_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_basic_weights();
    int seq[7] = '{0, 1, 1, 2, 3, 3, 3};
    cfg_write(0, 1); cfg_write(1, 2); cfg_write(2, 1); cfg_write(3, 3);
    empty_in = 5'b10000;
    fill(1);
    for (int c = 0; c < 21; c++) begin
      predict();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic_model cyc %0d got %h required %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (wren_out !== 1'b1 || grant_port_out !== 3'(seq[c % 7])) begin
        errors++;
        $display("FAIL basic_seq cyc %0d got wren %b port %0d required wren 1 port %0d",
                 c, wren_out, grant_port_out, seq[c % 7]);
      end
      tick();
    end
  endtask

  task automatic test_disabled_skip();
    cfg_write(1, 0);
    empty_in = 5'b10101;
    for (int c = 0; c < 10; c++) begin
      predict();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL skip_model cyc %0d got %h required %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (rden_out !== 5'b01000) begin
        errors++;
        $display("FAIL skip_rden cyc %0d got %b required 01000", c, rden_out);
      end
      tick();
    end
    cfg_write(1, 2);
  endtask

  task automatic test_backpressure();
    int held;
    empty_in = 5'b10000;
    fill(1);
    held = 0;
    for (int c = 0; c < 14; c++) begin
      full_in = (c >= 4 && c < 9);
      predict();
      if (c == 4) held = e_sel;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_model cyc %0d got %h required %h", c, obs_vec(), exp_vec());
      end
      if (full_in) begin
        checks++;
        if (wren_out !== 1'b0 || rden_out !== '0) begin
          errors++;
          $display("FAIL bp_hold cyc %0d got wren %b rden %b required 0/0", c, wren_out, rden_out);
        end
      end
      if (c == 9) begin
        checks++;
        if (wren_out !== 1'b1 || grant_port_out !== 3'(held)) begin
          errors++;
          $display("FAIL bp_resume got port %0d required %0d", grant_port_out, held);
        end
      end
      tick();
    end
    full_in = 1'b0;
  endtask

  task automatic test_transactional();
    int gseq[5] = '{0, 0, 0, 1, 1};
    bit lseq[5] = '{0, 1, 1, 0, 0};
    int w0;
    do_reset();
    empty_in = 5'b11100;
    fill(1);
    w0 = 0;
    for (int c = 0; c < 5; c++) begin
      data_in[0] = {(w0 == 2), 3'b000, 4'(w0)};
      empty_in[0] = (w0 >= 3);
      predict();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL tx_model cyc %0d got %h required %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (wren_out !== 1'b1 || grant_port_out !== 3'(gseq[c]) || locked_out !== lseq[c]) begin
        errors++;
        $display("FAIL tx_seq cyc %0d got port %0d lock %b required port %0d lock %b",
                 c, grant_port_out, locked_out, gseq[c], lseq[c]);
      end
      tick();
      if (e_wren && e_sel == 0) w0++;
    end
  endtask

  task automatic test_live_reconfig();
    int seq[23] = '{0, 1, 2, 2, 3, 0, 1, 2, 2, 2, 2, 2, 3, 0, 1, 2, 2, 2, 2, 2, 3, 0, 1};
    do_reset();
    cfg_write(2, 2);
    empty_in = 5'b10000;
    fill(1);
    for (int c = 0; c < 23; c++) begin
      cfg_valid  = (c == 3) || (c == 13);
      cfg_port   = (c == 13) ? 3'd7 : 3'd2;
      cfg_weight = (c == 13) ? 4'd9 : 4'd5;
      predict();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reconfig_model cyc %0d got %h required %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (wren_out !== 1'b1 || grant_port_out !== 3'(seq[c])) begin
        errors++;
        $display("FAIL reconfig_seq cyc %0d got port %0d required %0d", c, grant_port_out, seq[c]);
      end
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    empty_in = 5'b11110;
    fill(0);
    for (int c = 0; c < 2; c++) begin
      predict();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL arst_pre cyc %0d got %h required %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wren_out, locked_out, rden_out} !== '0) begin
      errors++;
      $display("FAIL arst_drop got %b required 0", {wren_out, locked_out, rden_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    empty_in = 5'b10000;
    fill(1);
    predict();
    checks++;
    if (obs_vec() !== exp_vec() || wren_out !== 1'b1 || grant_port_out !== 3'd0) begin
      errors++;
      $display("FAIL arst_first got %h port %0d required %h port 0", obs_vec(), grant_port_out, exp_vec());
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        empty_in[i] = ($urandom_range(0, 9) < 3);
        data_in[i]  = 8'($urandom);
      end
      full_in    = ($urandom_range(0, 4) == 0);
      cfg_valid  = ($urandom_range(0, 9) == 0);
      cfg_port   = 3'($urandom_range(0, 7));
      cfg_weight = 4'($urandom_range(0, 15));
      predict();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_model cyc %0d got %h required %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    cfg_valid = 1'b0;
`ifdef KANAGAWA_WRR_GRANT_COUNT_EN
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (grant_count_out[i] !== 16'(m_cnt[i])) begin
        errors++;
        $display("FAIL grant_count port %0d got %0d required %0d", i, grant_count_out[i], m_cnt[i]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_weights();
    test_disabled_skip();
    test_backpressure();
    test_transactional();
    test_live_reconfig();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kanagawa_weighted_rr_arbiter.md
# kanagawa_weighted_rr_arbiter

N-port weighted round-robin arbiter that shares one downstream FIFO write port between `NUM_PORTS` show-ahead FIFO sources. Each port gets a runtime-programmable weight: the number of consecutive transactions it may send before ownership rotates. The optional transactional mode keeps the grant on one port until its end-of-transaction bit is popped. It replaces cascaded two-input arbitration chains where more than two requesters need tunable, starvation-free bandwidth shares.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..16.
- `WIDTH`, 8: data word width.
- `IS_TRANSACTIONAL`, 0: 1 = hold grant until end-of-transaction word.
- `END_TRANSACTION_OFFSET`, 0: bit index in the data word that marks the end of a transaction.
- `WEIGHT_WIDTH`, 4: width of each weight and of the credit counter.
- `PW`, derived as `$clog2(NUM_PORTS)`. Not overridable.

Ports:
- `clk`  in  1: clock. Single clock domain.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `data_in`  in  [NUM_PORTS][WIDTH]: show-ahead heads of the source FIFOs.
- `empty_in`  in  NUM_PORTS: source FIFO empty flags.
- `rden_out`  out  NUM_PORTS: pop strobe, one-hot or zero.
- `data_out`  out  WIDTH: the selected `data_in`.
- `wren_out`  out  1: write strobe to the sink.
- `full_in`  in  1: sink full.
- `cfg_valid`  in  1: weight write strobe.
- `cfg_port`  in  PW: target port of the weight write.
- `cfg_weight`  in  WEIGHT_WIDTH: new weight value.
- `grant_port_out`  out  PW: selected port `sel`. Valid when `wren_out`=1.
- `locked_out`  out  1: registered flag, set while inside a multi-word transaction.

## Operation
State registers, with reset values:
- `weight[i]` = 1.
- `credit` = 0.
- `owner` = NUM_PORTS-1, so the first scan starts at port 0.
- `locked` = 0.

Port eligibility:
- `elig[i]` = !empty_in[i] && weight[i]!=0.

Selection is combinational and evaluated every cycle, in priority order:
1. **Locked.** `locked`=1: `sel`=`owner`. A grant is possible only if !empty_in[owner]. The weight is ignored.
2. **Continue.** `elig[owner]` && `credit`!=0: `sel`=`owner`, `cur`=`credit`.
3. **Rotate.** Otherwise `sel` is the first eligible port scanning owner+1, owner+2, … with modulo wrap. The owner itself is checked last. `cur`=`weight[sel]`.
4. **None.** No eligible port: no grant.

Grant and pop:
- `wren_out` = grant && !full_in && rst_n.
- `rden_out[sel]` = `wren_out`.
- `end_tx` = IS_TRANSACTIONAL ? data_in[sel][END_TRANSACTION_OFFSET] : 1.

Registered update, only when `wren_out`=1:
- `owner` <= `sel`.
- If `end_tx`: `locked` <= 0 and `credit` <= `cur`-1. Case 1 uses `cur`=`credit`, floored at 0.
- If not `end_tx`: `locked` <= 1. `credit` <= `cur`, with no decrement until the transaction ends.

When `wren_out`=0, all state holds.

Configuration writes:
- `cfg_valid`: `weight[cfg_port]` <= `cfg_weight`.
- `cfg_port` ≥ NUM_PORTS: the write is ignored.
- The new weight affects only later reloads. The live `credit` is not modified.
- Weight 0 disables a port. If the owner is set to 0 mid-transaction, the transaction still completes (locked case), then rotation skips that port.
- A config write in the same cycle as a grant is legal. The reload in that cycle uses the old weight.

Fairness:
- An eligible port with weight ≥1 is granted within (NUM_PORTS-1) × max-weight transactions of the other ports.

## Timing
- Zero-cycle combinational paths: `empty_in`/`full_in` → `rden_out`/`wren_out`/`data_out`/`grant_port_out`. Matches show-ahead FIFO semantics.
- Throughput: 1 word per cycle, including back-to-back ownership changes. There are no bubbles on rotation.
- `full_in`=1: no pop, state frozen. The selection may change if `empty_in` changes, but no state is committed.
- Reset: `rst_n` low asynchronously clears all registers and forces `rden_out`=0, `wren_out`=0, `locked_out`=0. `grant_port_out` is undefined-but-stable (0).
- Reset asserted mid-transaction drops the lock. The sink sees a truncated transaction. Upstream must also reset.
- Credit arithmetic: unsigned, WEIGHT_WIDTH bits, never wraps below 0.

## Configuration
- `KANAGAWA_WRR_GRANT_COUNT_EN` defined: adds output port `grant_count_out` [NUM_PORTS][16].
  - Entry i increments on each `wren_out` with `sel`=i.
  - Saturates at 0xFFFF.
  - Asynchronously cleared by `rst_n`.
- Not defined: the port and counters are absent. All other behaviour is identical.

## Test plan
- **Basic weights.** NUM_PORTS=4, weights {1,2,1,3}, all ports always non-empty, `full_in`=0, non-transactional → grant sequence 0,1,1,2,3,3,3 repeating, `wren_out`=1 every cycle.
- **Disabled port and skip.** Weight[1]=0, ports 0 and 2 empty → only ports 1/3 non-empty. Port 1 is never granted; port 3 is granted every cycle; `rden_out`=4'b1000.
- **Transactional lock.** IS_TRANSACTIONAL=1, port 0 sends 3 words with end bit on word 3, port 1 always ready → `grant_port_out`=0 for 3 consecutive grants, `locked_out`=1 after words 1 and 2, then the grant moves to 1.
- **Backpressure.** `full_in`=1 for 5 cycles mid-sequence → `wren_out`=0, `rden_out`=0, the sequence resumes at the same port and credit.
- **Live reconfiguration.** Write weight[2]=5 while port 2 owns with credit 1 → the current credit runs out first; the next reload of port 2 gives 5 consecutive grants. A write with `cfg_port`=7 (NUM_PORTS=4) leaves all weights unchanged.
- **Async reset.** Drop `rst_n` mid-transaction, between edges → `wren_out`/`locked_out` go to 0 immediately. After release, the first grant goes to the lowest eligible port (0).
